// File: rtl/serial_adder_pkg.sv
//------------------------------------------------------------------------------
// Module   : serial_adder_pkg
// Brief    : Shared state encoding and default width for the serial adder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package serial_adder_pkg;

  localparam int SA_DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fa_bit_cell.sv
//------------------------------------------------------------------------------
// Module   : fa_bit_cell
// Brief    : One-bit combinational full-adder cell.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fa_bit_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
//------------------------------------------------------------------------------
// Module   : serial_adder_ctrl
// Brief    : Bit-serial WIDTH-bit adder, LSB first, with valid/ready in and out.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_msb_q, c_msb_d;
  logic             cell_s, cell_co;

  fa_bit_cell u_cell (
    .x  (opa_q[0]),
    .y  (opb_q[0]),
    .ci (carry_q),
    .s  (cell_s),
    .co (cell_co)
  );

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_msb_d = c_msb_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          cnt_d   = '0;
          res_d   = '0;
          c_msb_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = {cell_s, res_q[WIDTH-1:1]};
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = cell_co;
        cnt_d   = cnt_q + CW'(1);
        // carry entering the MSB position feeds the signed-overflow flag
        if (cnt_q == LAST_BIT) begin
          c_msb_d = carry_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_msb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_msb_q <= c_msb_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = out_valid ? res_q : '0;
  assign cout      = out_valid & carry_q;
  assign ovf       = out_valid & (c_msb_q ^ carry_q);

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_serial_adder_ctrl
// Brief    : Self-checking bench for serial_adder_ctrl at WIDTH 2, 8 and 16.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic        cin;
  logic [15:0] a, b;
  int          sel;
  int          cur_w;
  int          n_cmp = 0;
  int          n_err = 0;

  logic        rdy2, vld2, co2, ov2;
  logic [1:0]  sum2;
  logic        rdy8, vld8, co8, ov8;
  logic [7:0]  sum8;
  logic        rdy16, vld16, co16, ov16;
  logic [15:0] sum16;

  logic        obs_in_ready, obs_out_valid;
  logic [17:0] obs_res;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid && sel == 0), .in_ready(rdy2),
    .a(a[1:0]), .b(b[1:0]), .cin(cin), .out_valid(vld2), .out_ready(out_ready),
    .sum(sum2), .cout(co2), .ovf(ov2)
  );

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid && sel == 1), .in_ready(rdy8),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .out_valid(vld8), .out_ready(out_ready),
    .sum(sum8), .cout(co8), .ovf(ov8)
  );

  serial_adder_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid && sel == 2), .in_ready(rdy16),
    .a(a), .b(b), .cin(cin), .out_valid(vld16), .out_ready(out_ready),
    .sum(sum16), .cout(co16), .ovf(ov16)
  );

  // {ovf, cout, sum zero-extended to 16} of whichever instance is under test
  always_comb begin
    obs_in_ready  = 1'b0;
    obs_out_valid = 1'b0;
    obs_res       = '0;
    case (sel)
      0: begin obs_in_ready = rdy2;  obs_out_valid = vld2;  obs_res = {ov2, co2, 14'd0, sum2}; end
      1: begin obs_in_ready = rdy8;  obs_out_valid = vld8;  obs_res = {ov8, co8, 8'd0, sum8}; end
      2: begin obs_in_ready = rdy16; obs_out_valid = vld16; obs_res = {ov16, co16, sum16}; end
      default: ;
    endcase
  end

  function automatic logic [17:0] model(input int w, input logic [15:0] x, input logic [15:0] y,
                                        input logic c);
    logic [16:0] mask, xm, ym, full;
    logic [15:0] s;
    logic        co, ov;
    mask = (17'd1 << w) - 17'd1;
    xm   = {1'b0, x} & mask;
    ym   = {1'b0, y} & mask;
    full = xm + ym + {16'd0, c};
    s    = full[15:0] & mask[15:0];
    co   = full[w];
    ov   = (xm[w-1] == ym[w-1]) && (s[w-1] != xm[w-1]);
    return {ov, co, s};
  endfunction

  // Present an operand set, wait for the accept edge, then measure edges to out_valid.
  task automatic accept_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
    int guard;
    int lat;
    bit busy_ok;
    in_valid = 1'b1;
    a = ta; b = tb; cin = tc;
    guard = 0;
    while (!obs_in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    n_cmp++;
    if (guard >= 100) begin
      n_err++;
      $display("FAIL accept_wait: in_ready never rose (waited %0d cycles)", guard);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (!obs_out_valid && lat < cur_w + 6) begin
      if (obs_in_ready !== 1'b0 || obs_res !== 18'd0) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++;
    if (lat !== cur_w) begin
      n_err++;
      $display("FAIL latency w=%0d: got %0d edges after accept, want %0d", cur_w, lat, cur_w);
    end
    n_cmp++;
    if (!busy_ok) begin
      n_err++;
      $display("FAIL busy_outputs w=%0d: in_ready or result nonzero while running", cur_w);
    end
  endtask

  // Check the presented result, hold it for `stall` cycles with junk on the inputs, then release.
  task automatic finish_op(input logic [17:0] exp, input int stall);
    bit hold_ok;
    n_cmp++;
    if (obs_res !== exp || obs_out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL result w=%0d: got vld=%b {ovf,cout,sum}=%h want vld=1 %h",
               cur_w, obs_out_valid, obs_res, exp);
    end
    hold_ok = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom);
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      if (obs_res !== exp || obs_out_valid !== 1'b1 || obs_in_ready !== 1'b0) hold_ok = 1'b0;
    end
    n_cmp++;
    if (!hold_ok) begin
      n_err++;
      $display("FAIL hold w=%0d: result/valid/ready moved under backpressure, now %h want %h",
               cur_w, obs_res, exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_cmp++;
    if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0 || obs_res !== 18'd0) begin
      n_err++;
      $display("FAIL release w=%0d: got rdy=%b vld=%b res=%h want rdy=1 vld=0 res=0",
               cur_w, obs_in_ready, obs_out_valid, obs_res);
    end
  endtask

  task automatic test_reset();
    sel = 1; cur_w = 8;
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    a = 16'h00FF; b = 16'h0001; cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0 || obs_res !== 18'd0) begin
      n_err++;
      $display("FAIL reset_held: rdy=%b vld=%b res=%h want 1 0 0", obs_in_ready, obs_out_valid, obs_res);
    end
    in_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0 || obs_res !== 18'd0) begin
      n_err++;
      $display("FAIL reset_after: rdy=%b vld=%b res=%h want 1 0 0", obs_in_ready, obs_out_valid, obs_res);
    end
  endtask

  task automatic test_directed();
    logic [7:0]  da[5], db[5], ds[5];
    logic        dc[5], dco[5], dov[5];
    sel = 1; cur_w = 8;
    da = '{8'h00, 8'hFF, 8'h7F, 8'h80, 8'hA5};
    db = '{8'h00, 8'h01, 8'h01, 8'h80, 8'h5A};
    dc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ds = '{8'h00, 8'h00, 8'h80, 8'h01, 8'h00};
    dco = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    dov = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      accept_op({8'h00, da[i]}, {8'h00, db[i]}, dc[i]);
      finish_op({dov[i], dco[i], 8'h00, ds[i]}, i % 2);
    end
  endtask

  task automatic test_backpressure();
    sel = 1; cur_w = 8;
    accept_op(16'h00C3, 16'h0044, 1'b1);
    finish_op({1'b0, 1'b1, 16'h0008}, 5);
  endtask

  task automatic test_reset_midrun();
    bit quiet;
    sel = 1; cur_w = 8;
    in_valid = 1'b1; a = 16'h00FF; b = 16'h00FF; cin = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++;
    if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0 || obs_res !== 18'd0) begin
      n_err++;
      $display("FAIL reset_midrun: rdy=%b vld=%b res=%h want 1 0 0", obs_in_ready, obs_out_valid, obs_res);
    end
    quiet = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < cur_w + 4; i++) begin
      @(posedge clk); #1;
      if (obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1) quiet = 1'b0;
    end
    out_ready = 1'b0;
    n_cmp++;
    if (!quiet) begin
      n_err++;
      $display("FAIL discard: aborted operation produced out_valid or left IDLE");
    end
    accept_op(16'h0012, 16'h0034, 1'b0);
    finish_op({1'b0, 1'b0, 16'h0046}, 0);
  endtask

  task automatic test_back_to_back();
    logic [17:0] expq[$];
    logic [17:0] e;
    int t, last, results;
    bit acc;
    sel = 1; cur_w = 8;
    in_valid = 1'b1; out_ready = 1'b1;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    t = 0; last = -1; results = 0;
    while (results < 4 && t < 200) begin
      acc = obs_in_ready && in_valid;
      if (obs_out_valid) begin
        e = (expq.size() > 0) ? expq.pop_front() : 18'h3FFFF;
        n_cmp++;
        if (obs_res !== e) begin
          n_err++;
          $display("FAIL b2b_result: got %h want %h", obs_res, e);
        end
        results++;
      end
      if (acc) begin
        expq.push_back(model(cur_w, a, b, cin));
        if (last >= 0) begin
          n_cmp++;
          if (t - last !== cur_w + 2) begin
            n_err++;
            $display("FAIL b2b_interval: got %0d cycles want %0d", t - last, cur_w + 2);
          end
        end
        last = t;
      end
      @(posedge clk); #1;
      t++;
      if (acc) begin
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      end
    end
    n_cmp++;
    if (results < 4) begin
      n_err++;
      $display("FAIL b2b_timeout: got %0d results want 4", results);
    end
    in_valid = 1'b0;
    repeat (cur_w + 4) @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_random(input int s, input int w, input int n);
    logic [17:0] e;
    sel = s; cur_w = w;
    for (int i = 0; i < n; i++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      e = model(w, a, b, cin);
      accept_op(a, b, cin);
      finish_op(e, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    test_random(1, 8, 500);
    test_random(0, 2, 500);
    test_random(2, 16, 500);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial multi-bit adder controller that time-multiplexes a single one-bit full-adder cell across the bit positions of a WIDTH-bit operand pair. It accepts one operand set through a valid/ready handshake. It sequences the cell LSB-first for WIDTH cycles with a registered carry, then presents sum, carry-out and signed overflow through an output handshake. It is the sequencing layer above the lab's full-adder datapath and the first multi-cycle block in the design.

## Interface
- WIDTH, default 8: operand and sum width in bits; legal range WIDTH >= 2.
- clk  input  1: single clock; all state updates on the rising edge.
- reset  input  1: synchronous, active-high; sampled on the rising edge of clk.
- in_valid  input  1: operand set on a, b, cin is valid.
- in_ready  output  1: block can accept an operand set.
- a  input  WIDTH: operand A, unsigned or two's complement.
- b  input  WIDTH: operand B.
- cin  input  1: carry-in to bit 0.
- out_valid  output  1: sum, cout and ovf are valid.
- out_ready  input  1: consumer accepts the result.
- sum  output  WIDTH: a + b + cin, modulo 2^WIDTH.
- cout  output  1: carry out of bit WIDTH-1.
- ovf  output  1: signed overflow, defined as carry into bit WIDTH-1 XOR cout.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, capture a and b into shift registers, load the carry register with cin, clear the bit counter and the result register, and go to RUN.
- RUN:
  - Each cycle, the cell combines opA[0], opB[0] and the carry register into s and co.
  - s shifts into the result register MSB; the result shifts right by one.
  - opA and opB shift right by one.
  - The carry register loads co. The carry register value at entry to bit WIDTH-1 is also latched as c_msb.
  - The counter increments. When the counter reaches WIDTH-1 in a RUN cycle, the next state is DONE.
- DONE:
  - out_valid = 1. sum = result register; cout = carry register; ovf = c_msb ^ carry register.
  - On out_ready, go to IDLE.
  - No new operand is accepted in the DONE cycle, even if out_ready is high.
- in_ready is 1 only in IDLE. in_valid is ignored in RUN and DONE; operands on a, b, cin may change freely after the accept edge.
- Reset, including mid-RUN or mid-DONE: state becomes IDLE. Shift registers, counter, carry, c_msb and result are cleared. Any in-flight operation is discarded and no out_valid is produced for it.
- Arithmetic: result is exact modulo 2^WIDTH. {cout, sum} equals a + b + cin as an unsigned (WIDTH+1)-bit value.
- Counter width: $clog2(WIDTH).

## Timing
- Output values during and after reset:
  - While reset is sampled high, and after it, until the next accept: in_ready = 1 (IDLE), out_valid = 0.
  - sum, cout and ovf read 0 whenever state is not DONE.
- Latency: for an accept at edge k, RUN occupies cycles k+1 through k+WIDTH. out_valid rises in the cycle after edge k+WIDTH.
- out_valid and the result are held stable until the edge at which out_ready is sampled high.
- in_ready rises in the cycle after the out_valid && out_ready edge.
- Minimum accept-to-accept interval: WIDTH + 2 cycles with out_ready tied high.
- Outputs are registered or decoded directly from the state; there is no combinational path from any input to any output.

## Structure
- Shared package serial_adder_pkg holds:
  - the state enum typedef state_t (IDLE, RUN, DONE);
  - the default width constant SA_DEFAULT_WIDTH = 8.
- One sub-module, fa_bit_cell: purely combinational, with inputs x, y, ci and outputs s, co.
  - s = x ^ y ^ ci; co = majority(x, y, ci).
  - It is instantiated once; the controller owns all registers.

## Test plan
- Reset, then a=0x00, b=0x00, cin=0, accept at edge k -> out_valid first high after edge k+8. Required result: sum=0x00, cout=0, ovf=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
- a=0x80, b=0x80, cin=1 -> sum=0x01, cout=1, ovf=1. Then a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and a, b.
  - Required: sum, cout, ovf stable; in_ready=0; no second capture.
  - When out_ready goes high: in_ready=1 one cycle later.
- Reset asserted for 1 cycle at RUN cycle k+4 -> next cycle IDLE, in_ready=1, out_valid=0, outputs 0. Then a=0x12, b=0x34, cin=0 -> sum=0x46, cout=0.
- Random: 500 operand sets with random out_ready stalls -> every result matches a + b + cin. out_valid latency is exactly WIDTH+1 cycles after each accept edge. Repeat the run with WIDTH=2 and WIDTH=16.
